// File: rtl/rr_arbiter_idx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter_idx                                                           |
// | Registered round-robin arbiter presenting one-hot and binary grants      |
// | with a valid/ready handshake and a lock mode for multi-beat transfers.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rr_arbiter_idx #(
  parameter int NUM_REQUESTERS = 7,
  parameter     DIRECTION      = "LSB0",
  parameter int INDEX_WIDTH    = $clog2(NUM_REQUESTERS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      grant_ready,
  input  logic                      lock,
  output logic                      grant_valid,
  output logic [NUM_REQUESTERS-1:0] grant_oh,
  output logic [INDEX_WIDTH-1:0]    grant_idx
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam bit                     c_MSB0    = (DIRECTION == "MSB0");
  localparam logic [INDEX_WIDTH-1:0] c_LAST    = INDEX_WIDTH'(NUM_REQUESTERS - 1);
  localparam logic [INDEX_WIDTH-1:0] c_ONE     = INDEX_WIDTH'(1);
  localparam logic [INDEX_WIDTH-1:0] c_PTR_RST = c_MSB0 ? c_LAST : '0;
  localparam logic [NUM_REQUESTERS-1:0] c_OH_ONE = NUM_REQUESTERS'(1);

  logic [1:0]                r_state;
  logic [INDEX_WIDTH-1:0]    r_ptr;
  logic                      r_grant_valid;
  logic [NUM_REQUESTERS-1:0] r_grant_oh;
  logic [INDEX_WIDTH-1:0]    r_grant_idx;

  logic [INDEX_WIDTH-1:0]    w_next_ptr;
  logic [INDEX_WIDTH-1:0]    w_scan_ptr;
  logic [NUM_REQUESTERS-1:0] w_cand;
  logic                      w_win_valid;
  logic [INDEX_WIDTH-1:0]    w_win_idx;
  logic [NUM_REQUESTERS-1:0] w_win_oh;
  logic                      w_accept;

  assign w_accept = r_grant_valid & grant_ready;

  // Pointer moves just past the current winner, wrapping modulo N.
  always_comb begin
    w_next_ptr = r_ptr;
    if (c_MSB0) begin
      w_next_ptr = (r_grant_idx == '0) ? c_LAST : (r_grant_idx - c_ONE);
    end else begin
      w_next_ptr = (r_grant_idx == c_LAST) ? '0 : (r_grant_idx + c_ONE);
    end
  end

  // From IDLE arbitrate raw requests; after an accept exclude the requester just served.
  assign w_scan_ptr = (r_state == S_IDLE) ? r_ptr : w_next_ptr;
  assign w_cand     = (r_state == S_IDLE) ? request : (request & ~r_grant_oh);

  always_comb begin
    int pos;
    pos         = 0;
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      if (c_MSB0) begin
        pos = int'(w_scan_ptr) - k;
        if (pos < 0) pos = pos + NUM_REQUESTERS;
      end else begin
        pos = int'(w_scan_ptr) + k;
        if (pos >= NUM_REQUESTERS) pos = pos - NUM_REQUESTERS;
      end
      if (!w_win_valid && w_cand[pos]) begin
        w_win_valid = 1'b1;
        w_win_idx   = INDEX_WIDTH'(pos);
      end
    end
  end

  assign w_win_oh = c_OH_ONE << w_win_idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= c_PTR_RST;
      r_grant_valid <= 1'b0;
      r_grant_oh    <= '0;
      r_grant_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_valid) begin
            r_state       <= S_GRANT;
            r_grant_valid <= 1'b1;
            r_grant_oh    <= w_win_oh;
            r_grant_idx   <= w_win_idx;
          end
        end
        S_GRANT, S_LOCKED: begin
          if (w_accept) begin
            if (lock) begin
              r_state <= S_LOCKED;
            end else begin
              r_ptr <= w_next_ptr;
              if (w_win_valid) begin
                r_state       <= S_GRANT;
                r_grant_valid <= 1'b1;
                r_grant_oh    <= w_win_oh;
                r_grant_idx   <= w_win_idx;
              end else begin
                r_state       <= S_IDLE;
                r_grant_valid <= 1'b0;
                r_grant_oh    <= '0;
                r_grant_idx   <= '0;
              end
            end
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_grant_valid <= 1'b0;
          r_grant_oh    <= '0;
          r_grant_idx   <= '0;
        end
      endcase
    end
  end

  assign grant_valid = r_grant_valid;
  assign grant_oh    = r_grant_oh;
  assign grant_idx   = r_grant_idx;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_idx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rr_arbiter_idx                                                        |
// | Directed bench for rr_arbiter_idx with LSB0 and MSB0 instances.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rr_arbiter_idx;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] request;
  logic       grant_ready;
  logic       lock;

  logic       l_valid, m_valid;
  logic [6:0] l_oh, m_oh;
  logic [2:0] l_idx, m_idx;

  int vectors = 0;
  int errs    = 0;

  rr_arbiter_idx #(.NUM_REQUESTERS(7), .DIRECTION("LSB0")) u_lsb (
    .clk(clk), .reset(reset), .request(request), .grant_ready(grant_ready),
    .lock(lock), .grant_valid(l_valid), .grant_oh(l_oh), .grant_idx(l_idx)
  );

  rr_arbiter_idx #(.NUM_REQUESTERS(7), .DIRECTION("MSB0")) u_msb (
    .clk(clk), .reset(reset), .request(request), .grant_ready(grant_ready),
    .lock(lock), .grant_valid(m_valid), .grant_oh(m_oh), .grant_idx(m_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_l(input string tag, input logic v, input logic [6:0] oh, input logic [2:0] idx);
    chk({tag, "_valid"}, 32'(l_valid), 32'(v));
    chk({tag, "_oh"},    32'(l_oh),    32'(oh));
    chk({tag, "_idx"},   32'(l_idx),   32'(idx));
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    request     = '0;
    grant_ready = 1'b0;
    lock        = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; request = '0; grant_ready = 1'b0; lock = 1'b0;
    tick();
    chk_l("reset", 1'b0, 7'h00, 3'd0);
    chk("reset_msb_valid", 32'(m_valid), 32'd0);
    reset = 1'b1;

    // Single request with stall, then accept with no further requests.
    request = 7'b0000001;
    tick();
    chk_l("single", 1'b1, 7'b0000001, 3'd0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) request = 7'b0000110;
      tick();
      chk_l("stall", 1'b1, 7'b0000001, 3'd0);
    end
    grant_ready = 1'b1; request = '0;
    tick();
    chk_l("drain", 1'b0, 7'h00, 3'd0);

    // Full rotation, both scan directions together.
    do_reset();
    request = 7'h7F; grant_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rot_lsb_valid", 32'(l_valid), 32'd1);
      chk("rot_lsb_idx",   32'(l_idx),   32'(k % 7));
      chk("rot_lsb_oh",    32'(l_oh),    32'd1 << (k % 7));
      chk("rot_msb_valid", 32'(m_valid), 32'd1);
      chk("rot_msb_idx",   32'(m_idx),   32'(6 - (k % 7)));
      chk("rot_msb_oh",    32'(m_oh),    32'd1 << (6 - (k % 7)));
    end

    // Lock holds requester 2 across two accepts.
    do_reset();
    request = 7'b0001100;
    tick();
    chk_l("lock_first", 1'b1, 7'b0000100, 3'd2);
    grant_ready = 1'b1; lock = 1'b1;
    tick();
    chk_l("lock_hold1", 1'b1, 7'b0000100, 3'd2);
    tick();
    chk_l("lock_hold2", 1'b1, 7'b0000100, 3'd2);
    lock = 1'b0;
    tick();
    chk_l("lock_release", 1'b1, 7'b0001000, 3'd3);

    // Sole requester alternates grant and idle.
    do_reset();
    request = 7'b0100000; grant_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k % 2 == 0) chk_l("sole_on", 1'b1, 7'b0100000, 3'd5);
      else            chk_l("sole_off", 1'b0, 7'h00, 3'd0);
    end

    // Reset mid-grant with pointer moved away from zero.
    do_reset();
    request = 7'b0100000;
    tick();
    chk_l("mid_g5", 1'b1, 7'b0100000, 3'd5);
    grant_ready = 1'b1; request = 7'b0010000;
    tick();
    chk_l("mid_g4", 1'b1, 7'b0010000, 3'd4);
    grant_ready = 1'b0;
    tick();
    chk_l("mid_g4_hold", 1'b1, 7'b0010000, 3'd4);
    reset = 1'b0;
    tick();
    chk_l("mid_reset", 1'b0, 7'h00, 3'd0);
    reset = 1'b1; request = 7'b1100000;
    tick();
    chk_l("mid_after", 1'b1, 7'b0100000, 3'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
`default_nettype wire
